// File: rtl/s713_state_shell.sv
// rtl/s713_state_shell.sv - s713 state register shell with RUN/SHIFT/CAPTURE command FSM
// Optional S713_STATE_SHELL_MISR_EN adds a primary-output MISR (po in, misr_sig out).
module s713_state_shell #(
    parameter int NFF  = 19,
    parameter int CNTW = 16
`ifdef S713_STATE_SHELL_MISR_EN
    ,
    parameter int NPO  = 23
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_op,
    input  logic [CNTW-1:0] cmd_count,
    input  logic            scan_in,
    output logic            scan_out,
    output logic [NFF-1:0]  state_q,
    input  logic [NFF-1:0]  nxt_state,
`ifdef S713_STATE_SHELL_MISR_EN
    input  logic [NPO-1:0]  po,
    output logic [NPO-1:0]  misr_sig,
`endif
    output logic            busy,
    output logic            done
);

    localparam logic [1:0] OP_NOP     = 2'b00;
    localparam logic [1:0] OP_RUN     = 2'b01;
    localparam logic [1:0] OP_SHIFT   = 2'b10;
    localparam logic [1:0] OP_CAPTURE = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_SHIFT,
        S_FIN
    } fsm_t;

    fsm_t            fsm, fsm_d;
    logic [CNTW-1:0] cnt, cnt_d;
    logic [NFF-1:0]  st_d;
    logic            last;

`ifdef S713_STATE_SHELL_MISR_EN
    logic [NPO-1:0]  misr_d;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm      <= S_IDLE;
            cnt      <= '0;
            state_q  <= '0;
`ifdef S713_STATE_SHELL_MISR_EN
            misr_sig <= '0;
`endif
        end else begin
            fsm      <= fsm_d;
            cnt      <= cnt_d;
            state_q  <= st_d;
`ifdef S713_STATE_SHELL_MISR_EN
            misr_sig <= misr_d;
`endif
        end
    end

    // Outputs decode only registered state, so no input reaches an output combinationally.
    assign cmd_ready = (fsm == S_IDLE);
    assign busy      = (fsm == S_RUN) || (fsm == S_SHIFT);
    assign done      = (fsm == S_FIN);
    assign scan_out  = state_q[NFF-1];
    assign last      = (cnt <= CNTW'(1));

    always_comb begin
        fsm_d  = fsm;
        cnt_d  = cnt;
        st_d   = state_q;
`ifdef S713_STATE_SHELL_MISR_EN
        misr_d = misr_sig;
`endif
        case (fsm)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_RUN, OP_SHIFT: begin
`ifdef S713_STATE_SHELL_MISR_EN
                            if (cmd_op == OP_RUN) misr_d = '0;
`endif
                            if (cmd_count == '0) begin
                                fsm_d = S_FIN;
                            end else begin
                                cnt_d = cmd_count;
                                fsm_d = (cmd_op == OP_RUN) ? S_RUN : S_SHIFT;
                            end
                        end
                        OP_CAPTURE: begin
                            st_d  = nxt_state;
                            fsm_d = S_FIN;
                        end
                        OP_NOP: begin
                            fsm_d = S_IDLE;
                        end
                        default: begin
                            fsm_d = S_IDLE;
                        end
                    endcase
                end
            end
            S_RUN: begin
                st_d  = nxt_state;
                cnt_d = cnt - CNTW'(1);
`ifdef S713_STATE_SHELL_MISR_EN
                misr_d = {misr_sig[NPO-2:0], misr_sig[NPO-1] ^ misr_sig[4]} ^ po;
`endif
                if (last) fsm_d = S_FIN;
            end
            S_SHIFT: begin
                st_d  = {state_q[NFF-2:0], scan_in};
                cnt_d = cnt - CNTW'(1);
                if (last) fsm_d = S_FIN;
            end
            S_FIN: begin
                fsm_d = S_IDLE;
            end
            default: begin
                fsm_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_s713_state_shell.sv
// tb/tb_s713_state_shell.sv - table-driven self-checking bench for s713_state_shell
module tb_s713_state_shell;

    localparam int NFF  = 19;
    localparam int CNTW = 16;
    localparam int NPO  = 23;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_op;
    logic [CNTW-1:0] cmd_count;
    logic            scan_in;
    logic            scan_out;
    logic [NFF-1:0]  state_q;
    logic [NFF-1:0]  nxt_state;
    logic            busy;
    logic            done;
    logic [NPO-1:0]  po;
`ifdef S713_STATE_SHELL_MISR_EN
    logic [NPO-1:0]  misr_sig;
`endif

    logic            fen;
    logic [NFF-1:0]  fval;
    logic [NFF-1:0]  so_cap;

    int n_cmp  = 0;
    int n_fail = 0;

    // Stand-in for the s713 core: an incrementer unless a fixed value is forced.
    assign nxt_state = fen ? fval : state_q + NFF'(1);

    always #5 clk = ~clk;

    s713_state_shell dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_count (cmd_count),
        .scan_in   (scan_in),
        .scan_out  (scan_out),
        .state_q   (state_q),
        .nxt_state (nxt_state),
`ifdef S713_STATE_SHELL_MISR_EN
        .po        (po),
        .misr_sig  (misr_sig),
`endif
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        logic [1:0]     op;
        int             cnt;
        logic [NFF-1:0] data;
        logic           fen;
        logic [NFF-1:0] fval;
        logic [NFF-1:0] exp_st;
        int             exp_lat;
        int             exp_busy;
        logic [NFF-1:0] exp_so;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_cmd(input logic [1:0] op, input int cnt, input logic [NFF-1:0] data,
                          output int lat, output int nbusy);
        int idx;
        lat   = -1;
        nbusy = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_count = CNTW'(cnt);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        for (int j = 1; j <= 400; j++) begin
            if (j <= NFF) so_cap[NFF-j] = scan_out;
            if (busy) nbusy++;
            if (done) begin
                lat = j;
                break;
            end
            idx     = cnt - j;
            scan_in = (idx >= 0 && idx < NFF) ? data[idx] : 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        int lat, nb, ndone, rbad;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_count = '0;
        scan_in = 1'b0; fen = 1'b0; fval = '0; po = '0; so_cap = '0;

        vt[0]  = '{2'b10, 19, 19'h5A5A5, 1'b0, 19'h0,     19'h5A5A5, 20, 19, 19'h00000};
        vt[1]  = '{2'b10, 19, 19'h12345, 1'b0, 19'h0,     19'h12345, 20, 19, 19'h5A5A5};
        vt[2]  = '{2'b10, 19, 19'h00000, 1'b0, 19'h0,     19'h00000, 20, 19, 19'h12345};
        vt[3]  = '{2'b01,  3, 19'h00000, 1'b0, 19'h0,     19'h00003,  4,  3, 19'h0};
        vt[4]  = '{2'b11,  9, 19'h00000, 1'b1, 19'h7FFFF, 19'h7FFFF,  1,  0, 19'h0};
        vt[5]  = '{2'b01,  0, 19'h00000, 1'b0, 19'h0,     19'h7FFFF,  1,  0, 19'h0};
        vt[6]  = '{2'b01,  2, 19'h00000, 1'b0, 19'h0,     19'h00001,  3,  2, 19'h0};
        vt[7]  = '{2'b10,  0, 19'h00000, 1'b0, 19'h0,     19'h00001,  1,  0, 19'h0};
        vt[8]  = '{2'b10,  4, 19'h0000A, 1'b0, 19'h0,     19'h0001A,  5,  4, 19'h0};
        vt[9]  = '{2'b10, 25, 19'h00000, 1'b0, 19'h0,     19'h00000, 26, 25, 19'h0};
        vt[10] = '{2'b11,  0, 19'h00000, 1'b1, 19'h2AAAA, 19'h2AAAA,  1,  0, 19'h0};

        repeat (2) @(negedge clk);
        chk("rst_state",  32'(state_q),   32'h0);
        chk("rst_busy",   32'(busy),      32'h0);
        chk("rst_done",   32'(done),      32'h0);
        chk("rst_ready",  32'(cmd_ready), 32'h1);
        chk("rst_sout",   32'(scan_out),  32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            fen  = vt[i].fen;
            fval = vt[i].fval;
            do_cmd(vt[i].op, vt[i].cnt, vt[i].data, lat, nb);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vt[i].exp_lat));
            chk($sformatf("v%0d_busy", i),    32'(nb),  32'(vt[i].exp_busy));
            if (vt[i].op == 2'b10 && vt[i].cnt == NFF)
                chk($sformatf("v%0d_scan_out", i), 32'(so_cap), 32'(vt[i].exp_so));
            @(negedge clk);
            chk($sformatf("v%0d_state", i), 32'(state_q), 32'(vt[i].exp_st));
            chk($sformatf("v%0d_done_width", i), {30'h0, done, cmd_ready}, 32'h1);
            fen = 1'b0;
        end

        // Commands presented while busy must be ignored, not queued.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_count = 16'd3;
        @(negedge clk);
        cmd_op = 2'b10; cmd_count = 16'd5;
        ndone = 0; rbad = 0;
        for (int j = 1; j <= 6; j++) begin
            if (done) ndone++;
            if (j <= 4 && cmd_ready) rbad++;
            if (j == 4) cmd_valid = 1'b0;
            @(negedge clk);
        end
        chk("busy_ign_state", 32'(state_q), 32'h2AAAD);
        chk("busy_ign_ndone", 32'(ndone),   32'h1);
        chk("busy_ign_ready", 32'(rbad),    32'h0);

        // NOP is consumed silently.
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_count = 16'd7;
        @(negedge clk);
        cmd_valid = 1'b0;
        ndone = 0; rbad = 0;
        for (int j = 0; j < 3; j++) begin
            if (done) ndone++;
            if (busy || !cmd_ready) rbad++;
            @(negedge clk);
        end
        chk("nop_ndone", 32'(ndone),   32'h0);
        chk("nop_idle",  32'(rbad),    32'h0);
        chk("nop_state", 32'(state_q), 32'h2AAAD);

        // Reset in the middle of a long RUN aborts it without a done pulse.
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_count = 16'd100;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_state", 32'(state_q), 32'h0);
        chk("abort_ready", 32'(cmd_ready), 32'h1);
        chk("abort_busy",  32'(busy),  32'h0);
        ndone = 0;
        for (int j = 0; j < 5; j++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk("abort_ndone", 32'(ndone), 32'h0);

`ifdef S713_STATE_SHELL_MISR_EN
        chk("misr_rst", 32'(misr_sig), 32'h0);
        po = 23'h000001;
        do_cmd(2'b01, 1, '0, lat, nb);
        @(negedge clk);
        chk("misr_run1", 32'(misr_sig), 32'h000001);
        po = 23'h000000;
        do_cmd(2'b01, 2, '0, lat, nb);
        @(negedge clk);
        chk("misr_clear", 32'(misr_sig), 32'h000000);
        po = 23'h000001;
        do_cmd(2'b01, 3, '0, lat, nb);
        @(negedge clk);
        chk("misr_run3", 32'(misr_sig), 32'h000007);
        po = 23'h000000;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/s713_state_shell.md
Name: s713_state_shell

Overview:
- Sequential shell that restores the 19 flip-flops removed when s713 was converted to combinational logic.
- Holds the state register that drives the s713 pseudo-primary inputs G64..G82, and reloads it from the pseudo-primary next-state outputs n117..n207.
- Sits between the s713 combinational core and the test controller.
- Supports three commands, issued over a valid/ready handshake:
  - RUN: functional clocking for N cycles.
  - SHIFT: scan shift of N bits.
  - CAPTURE: a single functional load.

Parameters:
- NFF, 19, state width (number of s713 flip-flops).
- CNTW, 16, width of the command count and cycle counter.
- NPO, 23, number of s713 primary outputs observed (MISR build only).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  shell accepts a command this cycle
- cmd_op  in  2  00 NOP, 01 RUN, 10 SHIFT, 11 CAPTURE
- cmd_count  in  CNTW  RUN cycles or SHIFT bits
- scan_in  in  1  serial scan data
- scan_out  out  1  equal to state_q[NFF-1]
- state_q  out  NFF  to core; bit i drives G(64+i)
- nxt_state  in  NFF  from core; bit i is the i-th of n117,n122,...,n207
- po  in  NPO  core primary outputs, order G103BF..G101BF (MISR build only)
- busy  out  1  command in progress
- done  out  1  one-cycle pulse when a command completes

Behaviour:
- Reset: all state is synchronous to clk.
  - When rst_n=0 at a rising edge: state_q=0, FSM=IDLE, counter=0, busy=0, done=0.
  - cmd_ready is 1 in IDLE, so it is 1 immediately after reset.
  - Reset overrides everything, including a command in progress; the aborted command produces no done pulse.
- FSM states are IDLE, RUN, SHIFT, FIN.
- IDLE:
  - cmd_ready=1, busy=0.
  - Accept when cmd_valid & cmd_ready.
  - An accepted NOP is consumed with no effect and no done.
  - RUN or SHIFT with cmd_count=0: go to FIN, state_q unchanged.
  - RUN or SHIFT with cmd_count>0: counter <= cmd_count, go to RUN or SHIFT.
  - CAPTURE: state_q <= nxt_state at the accept edge, go to FIN; cmd_count is ignored.
- RUN:
  - Every cycle: state_q <= nxt_state and counter decrements.
  - When counter reaches 1, that cycle performs the final load and the FSM moves to FIN.
  - Exactly cmd_count loads occur, on consecutive cycles starting the cycle after accept.
- SHIFT:
  - Every cycle: state_q <= {state_q[NFF-2:0], scan_in} and counter decrements.
  - Exactly cmd_count shifts occur, with the same counting rule as RUN.
  - scan_out always shows the current state_q[NFF-1], so the first bit is visible before the first shift edge.
  - cmd_count may exceed NFF; shifting simply continues.
- FIN: done=1 for exactly one cycle, busy=0, then IDLE.
- busy: 1 in RUN and SHIFT.
- cmd_ready: 0 outside IDLE. cmd_valid outside IDLE is ignored, not queued. A command can be accepted in the cycle after done.
- The shell is fully synchronous with no combinational path from inputs to outputs, except scan_out, which is taken from a register.

Optional Feature:
- Macro S713_STATE_SHELL_MISR_EN.
- When defined:
  - Adds output misr_sig [NPO-1:0], reset to 0.
  - During each RUN load cycle: misr_sig <= {misr_sig[NPO-2:0], misr_sig[NPO-1]^misr_sig[4]} ^ po.
  - Cleared to 0 when a RUN command is accepted.
  - Holds its value in all other states.
- When undefined: no misr_sig port and no po port; all other behaviour is identical.

Test Plan:
- Reset, then SHIFT count=19 with scan_in = 0x5A5A5, MSB first -> state_q=0x5A5A5; done pulses 20 cycles after accept; busy=1 for 19 cycles.
- Preload 0x12345 by SHIFT, then SHIFT count=19 with scan_in=0 -> scan_out sequence is 0x12345 MSB first; final state_q=0.
- Bench model nxt_state=state_q+1, state 0, RUN count=3 -> state_q=3; done pulses once; cmd_valid asserted during busy is ignored and cmd_ready stays 0.
- CAPTURE with nxt_state forced to 0x7FFFF -> state_q=0x7FFFF one edge after accept; done the next cycle. RUN count=0 -> state_q unchanged; done one cycle after accept.
- rst_n=0 for one cycle in the middle of a RUN count=100 -> state_q=0; IDLE and cmd_ready=1 the next cycle; no done pulse.
- MISR build: RUN count=1 from misr_sig=0 with po=0x000001 -> misr_sig=0x000001. RUN count=2 with po=0 -> misr_sig=0 (cleared at accept).
